// File: rtl/projector_point_mux.sv
// projector_point_mux: arbitrates N_SRC point producers into a FIFO that feeds the projector DAC and laser
module projector_point_mux #(
    parameter int N_SRC   = 4,
    parameter int SEL_W   = 2,
    parameter int COORD_W = 12,
    parameter int DATA_W  = 2*COORD_W+8,
    parameter int DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      update,
    input  logic [SEL_W-1:0]          sel,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    input  logic [N_SRC-1:0]          src_valid,
    output logic [N_SRC-1:0]          src_ready,
    output logic [COORD_W-1:0]        DAC_x,
    output logic [COORD_W-1:0]        DAC_y,
    output logic                      DAC_start,
    output logic [2:0]                laser_rgb,
    output logic                      frame_done,
    output logic                      underrun,
    output logic [15:0]               underrun_count,
    output logic [$clog2(DEPTH):0]    fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [SEL_W:0] NSRC = (SEL_W+1)'(N_SRC);

    typedef enum logic {FLUSH, RUN} state_t;

    state_t              state_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [AW:0]         count_q, count_d;
    logic [COORD_W-1:0]  dac_x_q, dac_y_q;
    logic [2:0]          rgb_q;
    logic                dac_start_q, frame_done_q, underrun_q;
    logic [15:0]         underrun_count_q;
    logic                run, in_rng, full, rdy, wr, pop, under, flush;
    logic [DATA_W-1:0]   wdata, head;
    logic                unused_rsvd;

    assign run         = state_q == RUN;
    assign in_rng      = {1'b0, sel} < NSRC;
    // full is taken from the registered level, so a same-cycle pop never frees a slot for a write
    assign full        = count_q == (AW+1)'(DEPTH);
    assign rdy         = run && in_rng && !full;
    assign src_ready   = rdy ? N_SRC'(1) << sel : '0;
    assign wr          = |(src_valid & src_ready);
    assign pop         = update && run && in_rng && count_q != '0;
    assign under       = update && run && in_rng && count_q == '0;
    // a source switch empties the FIFO on the switching edge and again on the flush edge
    assign flush       = !run || sel != sel_q;
    assign head        = mem_q[rptr_q];
    assign unused_rsvd = ^head[4:1];
    assign count_d     = count_q + (AW+1)'(wr) - (AW+1)'(pop);

    assign DAC_x          = dac_x_q;
    assign DAC_y          = dac_y_q;
    assign DAC_start      = dac_start_q;
    assign laser_rgb      = rgb_q;
    assign frame_done     = frame_done_q;
    assign underrun       = underrun_q;
    assign underrun_count = underrun_count_q;
    assign fifo_level     = count_q;

    // pick the word of the selected producer
    always_comb begin
        wdata = '0;
        for (int i = 0; i < N_SRC; i++) if (SEL_W'(i) == sel) wdata = src_data[i*DATA_W +: DATA_W];
    end

    // point storage; no reset needed since the level gates every read
    always_ff @(posedge clk) if (wr) mem_q[wptr_q] <= wdata;

    // pointers and occupancy, cleared on reset and whenever a flush is due
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr) wptr_q <= wptr_q + AW'(1);
            if (pop) rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // FLUSH/RUN mode control with registered DAC, laser and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= FLUSH;
            sel_q            <= sel;
            dac_x_q          <= '0;
            dac_y_q          <= '0;
            rgb_q            <= '0;
            dac_start_q      <= 1'b0;
            frame_done_q     <= 1'b0;
            underrun_q       <= 1'b0;
            underrun_count_q <= '0;
        end else begin
            dac_start_q  <= update;
            frame_done_q <= pop && head[0];
            underrun_q   <= under;
            if (under && underrun_count_q != 16'hFFFF) underrun_count_q <= underrun_count_q + 16'd1;
            if (pop) begin
                dac_x_q <= head[DATA_W-1 -: COORD_W];
                dac_y_q <= head[DATA_W-1-COORD_W -: COORD_W];
                rgb_q   <= head[7:5];
            end else if (!run || update) begin
                rgb_q   <= '0;
            end
            if (!run) begin
                state_q <= RUN;
            end else if (sel != sel_q) begin
                sel_q   <= sel;
                state_q <= FLUSH;
            end
        end
    end
endmodule

// File: tb/tb_projector_point_mux.sv
// tb_projector_point_mux: scoreboard bench for the projector point multiplexer
module tb_projector_point_mux;
    localparam int W = 32;

    logic            clk = 1'b0, reset = 1'b1, update = 1'b0;
    logic [1:0]      sel = 2'd2;
    logic [4*W-1:0]  src_data = '0;
    logic [3:0]      src_valid = '0;
    logic [3:0]      src_ready;
    logic [11:0]     DAC_x, DAC_y;
    logic            DAC_start, frame_done, underrun;
    logic [2:0]      laser_rgb;
    logic [15:0]     underrun_count;
    logic [4:0]      fifo_level;

    logic            update3 = 1'b0;
    logic [1:0]      sel3 = 2'd0;
    logic [3*W-1:0]  src_data3 = '0;
    logic [2:0]      src_valid3 = '0;
    logic [2:0]      src_ready3;
    logic [11:0]     dx3, dy3;
    logic            ds3, fd3, ur3;
    logic [2:0]      rgb3;
    logic [15:0]     cnt3;
    logic [4:0]      lvl3;

    projector_point_mux dut (
        .clk(clk), .reset(reset), .update(update), .sel(sel), .src_data(src_data),
        .src_valid(src_valid), .src_ready(src_ready), .DAC_x(DAC_x), .DAC_y(DAC_y),
        .DAC_start(DAC_start), .laser_rgb(laser_rgb), .frame_done(frame_done),
        .underrun(underrun), .underrun_count(underrun_count), .fifo_level(fifo_level)
    );

    projector_point_mux #(.N_SRC(3)) u3 (
        .clk(clk), .reset(reset), .update(update3), .sel(sel3), .src_data(src_data3),
        .src_valid(src_valid3), .src_ready(src_ready3), .DAC_x(dx3), .DAC_y(dy3),
        .DAC_start(ds3), .laser_rgb(rgb3), .frame_done(fd3),
        .underrun(ur3), .underrun_count(cnt3), .fifo_level(lvl3)
    );

    always #5 clk = ~clk;

    int          vec = 0, errs = 0;
    logic [31:0] sbq [$];
    logic [31:0] e;
    logic [11:0] lx = '0, ly = '0;
    logic [28:0] obs;

    assign obs = {DAC_x, DAC_y, laser_rgb, DAC_start, frame_done};

    function automatic logic [31:0] mk(input logic [11:0] x, input logic [11:0] y, input logic [2:0] c, input logic eof);
        return {x, y, c, 4'b0, eof};
    endfunction

    function automatic logic [28:0] ex(input logic [31:0] w);
        return {w[31:20], w[19:8], w[7:5], 1'b1, w[0]};
    endfunction

    task automatic strobe();
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic push(input int p, input logic [31:0] w);
        src_data[p*W +: W] = w;
        src_valid[p] = 1'b1;
        @(negedge clk);
        src_valid[p] = 1'b0;
        sbq.push_back(w);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vec++;
        if ({obs, underrun, underrun_count, fifo_level} !== '0) begin
            errs++; $display("FAIL reset_state: got out=%h ur=%b cnt=%h lvl=%0d want all 0", obs, underrun, underrun_count, fifo_level);
        end
        reset = 1'b0;
        vec++;
        if (src_ready !== 4'b0000) begin errs++; $display("FAIL reset_flush_ready: got %b want 0000", src_ready); end
        @(negedge clk);
        vec++;
        if (src_ready !== 4'b0100) begin errs++; $display("FAIL reset_run_ready: got %b want 0100", src_ready); end
    endtask

    task automatic test_basic();
        push(2, mk(12'h123, 12'h456, 3'd5, 1'b0));
        push(2, mk(12'h010, 12'h020, 3'd3, 1'b0));
        push(2, mk(12'h7FF, 12'h001, 3'd1, 1'b1));
        vec++;
        if (fifo_level !== 5'd3) begin errs++; $display("FAIL basic_level: got %0d want 3", fifo_level); end
        for (int i = 0; i < 3; i++) begin
            strobe();
            e = sbq.pop_front();
            lx = e[31:20];
            ly = e[19:8];
            vec++;
            if (obs !== ex(e)) begin errs++; $display("FAIL basic_pop%0d: got %h want %h", i, obs, ex(e)); end
            vec++;
            if (fifo_level !== 5'(2 - i)) begin errs++; $display("FAIL basic_level%0d: got %0d want %0d", i, fifo_level, 2 - i); end
            @(negedge clk);
            vec++;
            if ({DAC_start, frame_done} !== 2'b00) begin errs++; $display("FAIL basic_pulse%0d: got start/eof %b%b want 00", i, DAC_start, frame_done); end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_underrun();
        for (int k = 1; k <= 2; k++) begin
            strobe();
            vec++;
            if ({DAC_x, DAC_y, laser_rgb, DAC_start, underrun, underrun_count} !== {lx, ly, 3'b0, 1'b1, 1'b1, 16'(k)}) begin
                errs++; $display("FAIL underrun%0d: got x=%h y=%h rgb=%0d st=%b ur=%b cnt=%0d want x=%h y=%h rgb=0 st=1 ur=1 cnt=%0d", k, DAC_x, DAC_y, laser_rgb, DAC_start, underrun, underrun_count, lx, ly, k);
            end
            @(negedge clk);
            vec++;
            if (underrun !== 1'b0) begin errs++; $display("FAIL underrun_pulse%0d: got %b want 0", k, underrun); end
        end
        force dut.underrun_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.underrun_count_q;
        strobe();
        vec++;
        if ({underrun, underrun_count} !== {1'b1, 16'hFFFF}) begin
            errs++; $display("FAIL underrun_sat: got ur=%b cnt=%h want ur=1 cnt=ffff", underrun, underrun_count);
        end
    endtask

    task automatic test_full();
        int n;
        logic [31:0] w;
        sel = 2'd1;
        repeat (2) @(negedge clk);
        sbq.delete();
        n = 0;
        src_valid[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            w = mk(12'(c), 12'(100 + c), 3'(c % 7 + 1), 1'b0);
            src_data[W +: W] = w;
            vec++;
            if (src_ready[1] !== (n < 16)) begin errs++; $display("FAIL full_ready c%0d: got %b want %b", c, src_ready[1], n < 16); end
            if (n < 16) begin sbq.push_back(w); n++; end
            @(negedge clk);
        end
        vec++;
        if (fifo_level !== 5'd16) begin errs++; $display("FAIL full_level: got %0d want 16", fifo_level); end
        strobe();
        e = sbq.pop_front();
        vec++;
        if (obs !== ex(e)) begin errs++; $display("FAIL full_pop: got %h want %h", obs, ex(e)); end
        vec++;
        if ({fifo_level, src_ready[1]} !== {5'd15, 1'b1}) begin errs++; $display("FAIL full_pop_level: got lvl=%0d rdy=%b want 15 1", fifo_level, src_ready[1]); end
        sbq.push_back(src_data[W +: W]);
        @(negedge clk);
        src_valid[1] = 1'b0;
        vec++;
        if (fifo_level !== 5'd16) begin errs++; $display("FAIL full_refill: got %0d want 16", fifo_level); end
    endtask

    task automatic test_flush();
        sel = 2'd0;
        repeat (2) @(negedge clk);
        sbq.delete();
        for (int i = 0; i < 5; i++) push(0, mk(12'(12'h200 + i), 12'(12'h300 + i), 3'(i + 2), 1'b0));
        vec++;
        if (fifo_level !== 5'd5) begin errs++; $display("FAIL flush_fill: got %0d want 5", fifo_level); end
        strobe();
        e = sbq.pop_front();
        vec++;
        if (obs !== ex(e)) begin errs++; $display("FAIL flush_prepop: got %h want %h", obs, ex(e)); end
        sel = 2'd3;
        src_data[0 +: W] = mk(12'hBAD, 12'hBAD, 3'd7, 1'b1);
        src_valid[0] = 1'b1;
        @(negedge clk);
        vec++;
        if ({src_ready, fifo_level} !== {4'b0000, 5'd0}) begin errs++; $display("FAIL flush_cycle: got rdy=%b lvl=%0d want 0000 0", src_ready, fifo_level); end
        sbq.delete();
        @(negedge clk);
        vec++;
        if ({laser_rgb, src_ready} !== {3'b0, 4'b1000}) begin errs++; $display("FAIL flush_after: got rgb=%0d rdy=%b want 0 1000", laser_rgb, src_ready); end
        push(3, mk(12'hA00, 12'hB00, 3'd7, 1'b0));
        push(3, mk(12'hA01, 12'hB01, 3'd6, 1'b1));
        vec++;
        if (fifo_level !== 5'd2) begin errs++; $display("FAIL flush_newlevel: got %0d want 2", fifo_level); end
        for (int i = 0; i < 2; i++) begin
            strobe();
            e = sbq.pop_front();
            vec++;
            if (obs !== ex(e)) begin errs++; $display("FAIL flush_pop%0d: got %h want %h", i, obs, ex(e)); end
        end
        src_valid[0] = 1'b0;
    endtask

    task automatic test_out_of_range();
        sel3 = 2'd3;
        src_valid3 = 3'b111;
        repeat (2) @(negedge clk);
        vec++;
        if ({src_ready3, lvl3} !== {3'b000, 5'd0}) begin errs++; $display("FAIL oor_ready: got rdy=%b lvl=%0d want 000 0", src_ready3, lvl3); end
        update3 = 1'b1;
        @(negedge clk);
        update3 = 1'b0;
        vec++;
        if ({rgb3, ds3, ur3, cnt3, lvl3} !== {3'b0, 1'b1, 1'b0, 16'd0, 5'd0}) begin
            errs++; $display("FAIL oor_update: got rgb=%0d st=%b ur=%b cnt=%0d lvl=%0d want 0 1 0 0 0", rgb3, ds3, ur3, cnt3, lvl3);
        end
        src_valid3 = '0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) push(3, mk(12'(12'h400 + i), 12'(12'h500 + i), 3'(i % 7 + 1), 1'b0));
        strobe();
        e = sbq.pop_front();
        vec++;
        if ({obs, fifo_level} !== {ex(e), 5'd8}) begin errs++; $display("FAIL rmid_pre: got %h lvl=%0d want %h lvl=8", obs, fifo_level, ex(e)); end
        reset = 1'b1;
        update = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        update = 1'b0;
        vec++;
        if ({obs, underrun, underrun_count, fifo_level} !== '0) begin
            errs++; $display("FAIL rmid_zero: got out=%h ur=%b cnt=%h lvl=%0d want all 0", obs, underrun, underrun_count, fifo_level);
        end
        sbq.delete();
        vec++;
        if (src_ready !== 4'b0000) begin errs++; $display("FAIL rmid_flush_ready: got %b want 0000", src_ready); end
        strobe();
        vec++;
        if ({obs, underrun, underrun_count, fifo_level} !== {24'h0, 3'b0, 1'b1, 1'b0, 1'b0, 16'd0, 5'd0}) begin
            errs++; $display("FAIL rmid_flush_update: got out=%h ur=%b cnt=%0d lvl=%0d want start only", obs, underrun, underrun_count, fifo_level);
        end
        push(3, mk(12'h0AB, 12'h0CD, 3'd4, 1'b1));
        strobe();
        e = sbq.pop_front();
        vec++;
        if (obs !== ex(e)) begin errs++; $display("FAIL rmid_resume: got %h want %h", obs, ex(e)); end
        strobe();
        vec++;
        if ({underrun, underrun_count} !== {1'b1, 16'd1}) begin errs++; $display("FAIL rmid_underrun: got ur=%b cnt=%0d want 1 1", underrun, underrun_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_full();
        test_flush();
        test_out_of_range();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
